// File: rtl/mux_stream_nt1.sv
// mux_stream_nt1: N-to-1 streaming multiplexer with valid/ready on every
// channel, a single registered output stage and packet-granular locking.
// Channel choice is external (select on s) when mode = 0, or round-robin
// over the valid channels when mode = 1.
module mux_stream_nt1 #(
    parameter int width    = 32,
    parameter int chanNum  = 4,
    parameter int selWidth = 2,
    parameter int mode     = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [selWidth-1:0]        s,
    input  logic [chanNum-1:0]         in_valid,
    input  logic [chanNum*width-1:0]   in_data,
    input  logic [chanNum-1:0]         in_last,
    output logic [chanNum-1:0]         in_ready,
    output logic                       out_valid,
    output logic [width-1:0]           out_data,
    output logic                       out_last,
    output logic [selWidth-1:0]        out_sel,
    input  logic                       out_ready
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [selWidth-1:0] lock_chan_q, lock_chan_d;
    logic [selWidth-1:0] ptr_q, ptr_d;
    logic                out_valid_q, out_valid_d;
    logic [width-1:0]    out_data_q, out_data_d;
    logic                out_last_q, out_last_d;
    logic [selWidth-1:0] out_sel_q, out_sel_d;

    logic                grant_vld_s;
    logic [selWidth-1:0] grant_idx_s;
    logic                rr_found_s;
    logic                rr_hit_s;
    int                  rr_idx_s;
    logic [chanNum-1:0]  valid_shift_s;
    logic                accept_s;
    logic                xfer_s;
    logic [chanNum*width-1:0] data_shift_s;
    logic [chanNum-1:0]  last_shift_s;
    logic [width-1:0]    grant_data_s;
    logic                grant_last_s;

    // Pick the granted channel: locked owner, external select, or round-robin search from ptr.
    always_comb begin
        grant_vld_s   = 1'b0;
        grant_idx_s   = '0;
        rr_found_s    = 1'b0;
        rr_hit_s      = 1'b0;
        rr_idx_s      = 0;
        valid_shift_s = '0;
        case (state_q)
            ST_LOCKED: begin
                grant_vld_s = 1'b1;
                grant_idx_s = lock_chan_q;
            end
            ST_IDLE: begin
                if (mode == 0) begin
                    // An out-of-range select simply grants nothing.
                    if (int'(s) < chanNum) begin
                        grant_vld_s = 1'b1;
                        grant_idx_s = s;
                    end else begin
                        grant_vld_s = 1'b0;
                        grant_idx_s = '0;
                    end
                end else begin
                    for (int k = 0; k < chanNum; k++) begin
                        // Explicit wrap so non-power-of-2 channel counts rotate correctly.
                        rr_idx_s      = int'(ptr_q) + k;
                        rr_idx_s      = (rr_idx_s >= chanNum) ? (rr_idx_s - chanNum) : rr_idx_s;
                        valid_shift_s = in_valid >> rr_idx_s;
                        rr_hit_s      = ~rr_found_s & valid_shift_s[0];
                        grant_idx_s   = rr_hit_s ? selWidth'(rr_idx_s) : grant_idx_s;
                        rr_found_s    = rr_found_s | rr_hit_s;
                    end
                    grant_vld_s = rr_found_s;
                end
            end
            default: begin
                grant_vld_s = 1'b0;
                grant_idx_s = '0;
            end
        endcase
    end

    // Drive the one-hot ready and extract the granted channel's beat.
    always_comb begin
        accept_s     = ~out_valid_q | out_ready;
        data_shift_s = in_data >> (int'(grant_idx_s) * width);
        last_shift_s = in_last >> grant_idx_s;
        grant_data_s = data_shift_s[width-1:0];
        grant_last_s = last_shift_s[0];
        if (rst_n && grant_vld_s && accept_s) begin
            in_ready = {{(chanNum-1){1'b0}}, 1'b1} << grant_idx_s;
        end else begin
            in_ready = '0;
        end
        xfer_s = |(in_valid & in_ready);
    end

    // Next-state for output register, lock FSM and round-robin pointer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_sel_d   = out_sel_q;
        state_d     = state_q;
        lock_chan_d = lock_chan_q;
        ptr_d       = ptr_q;

        // A new beat overwrites the held one even while it drains, so there is no bubble.
        if (xfer_s) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data_s;
            out_last_d  = grant_last_s;
            out_sel_d   = grant_idx_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (xfer_s && !grant_last_s) begin
                    state_d     = ST_LOCKED;
                    lock_chan_d = grant_idx_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (xfer_s && grant_last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((mode == 1) && xfer_s && grant_last_s) begin
            ptr_d = (grant_idx_s == selWidth'(chanNum - 1)) ? '0 : (grant_idx_s + selWidth'(1'b1));
        end else begin
            ptr_d = ptr_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            lock_chan_q <= '0;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_sel_q   <= '0;
        end else begin
            state_q     <= state_d;
            lock_chan_q <= lock_chan_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_sel   = out_sel_q;

endmodule
